sound_glu: RTL
==============

Name: sound_glu

Overview:
- Host-side bridge between the 65816 bus and the ES5503 DOC and its 64 KB sound RAM, modelling the IIgs Sound GLU at $C03C-$C03F.
- Drives the DOC register interface (wr, reg_addr, reg_data_in) and captures DOC data_out.
- Performs host reads and writes of sound RAM through a request/acknowledge arbiter port that the DOC fetch path shares.
- Applies the 4-bit master volume to the DOC sound output.

Parameters:
- RAM_AW, 16, sound RAM address width (64 KB).
- RAM_TIMEOUT, 15, maximum cycles to wait for ram_ack before the access is abandoned.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- cpu_addr  in  2  register select: 0=control, 1=data, 2=addr_lo, 3=addr_hi.
- cpu_wr  in  1  one-cycle write strobe.
- cpu_rd  in  1  one-cycle read strobe.
- cpu_din  in  8  write data.
- cpu_dout  out  8  read data, registered.
- doc_wr  out  1  DOC write strobe.
- doc_reg_addr  out  8  DOC register address.
- doc_reg_data  out  8  DOC write data.
- doc_data_in  in  8  DOC data_out; valid one cycle after doc_reg_addr is driven.
- ram_req  out  1  sound RAM access request.
- ram_we  out  1  write qualifier for the request.
- ram_addr  out  16  RAM address.
- ram_wdata  out  8  RAM write data.
- ram_rdata  in  8  RAM read data; valid in the ram_ack cycle.
- ram_ack  in  1  one-cycle grant/complete.
- snd_in  in  16  DOC sound_out.
- snd_out  out  16  volume-scaled sound.

Behaviour:
- Reset values: cpu_dout=0, doc_wr=0, doc_reg_addr=8'h00, doc_reg_data=0, ram_req=0, ram_we=0, ram_addr=0, ram_wdata=0, snd_out=0. Control register=0, address pointer=0, data latch=0, state=IDLE.
- Control register:
  - [3:0] volume.
  - [5] auto-increment.
  - [6] target: 1=RAM, 0=DOC.
  - [7] busy; read-only. It reads 1 whenever state!=IDLE.
- Address pointer: 16 bits. addr_lo and addr_hi are written and read directly. For the DOC target only pointer[7:0] is used.
- Register accesses to control, addr_lo or addr_hi complete in the cycle of the strobe. cpu_dout updates on the next clock edge.
- Data write:
  - DOC target: state DOC_WR. doc_wr=1 for exactly one cycle, with doc_reg_addr=ptr[7:0] and doc_reg_data=cpu_din.
  - RAM target: state RAM_WR. ram_req=1 and ram_we=1 are held until ram_ack.
- Data read:
  - cpu_dout returns the current data latch. This is the IIgs dummy-read semantics: the first read returns stale data.
  - In the same cycle the block launches a fetch at the pointer.
  - DOC fetch: DOC_RD drives ptr[7:0] for one cycle, then DOC_CAP latches doc_data_in.
  - RAM fetch: RAM_RD holds ram_req until ram_ack, then latches ram_rdata.
- DOC OIR ($E0) pops the DOC IRQ stack whenever it is presented with wr=0. Outside DOC_RD, doc_reg_addr idles at 8'h00, and the block never presents an address in the $E0-$E3 range except in the single DOC_RD cycle.
- Auto-increment: when ctl[5]=1, the pointer increments by 1 when the access completes. It wraps $FFFF to $0000. For the DOC target it still increments all 16 bits.
- Timeout: an access with no ram_ack within RAM_TIMEOUT cycles returns to IDLE. On a read the data latch becomes 8'hFF. The pointer still increments.
- Strobes arriving while busy:
  - cpu_wr/cpu_rd to the data register are ignored, with no state change. Host software polls busy.
  - Writes to control, addr_lo and addr_hi while busy are ignored, except that volume ctl[3:0] is always writable.
- Simultaneous cpu_wr and cpu_rd: the write wins and the read is ignored.
- Reset mid-operation: the next edge forces IDLE and drops ram_req. A pending access is lost.
- snd_out = (signed snd_in * {1'b0, vol}) >>> 4, registered with 1 cycle latency. vol=15 gives 15/16 scale.

Optional Feature:
- Macro GLU_VOLUME_EN.
  - Defined: the volume scaling multiplier is present as above.
  - Undefined: snd_out=snd_in registered (1 cycle). ctl[3:0] remains readable and writable but has no effect.

Decomposition:
- Package sound_glu_pkg:
  - state enum {IDLE, DOC_WR, DOC_RD, DOC_CAP, RAM_WR, RAM_RD}.
  - register indices REG_CTL, REG_DATA, REG_ALO, REG_AHI.
  - control bit positions CTL_AUTOINC=5, CTL_RAM=6, CTL_BUSY=7.
  - DOC_IDLE_ADDR=8'h00.
- One sub-module: sound_glu_volume, containing the registered scaling and the GLU_VOLUME_EN gating.

Test Plan:
1. RAM write with auto-increment: ctl=8'h60, ptr=$1234, data write 8'hAB, ack after 3 cycles -> ram_addr=$1234, ram_wdata=$AB, ram_we=1; ptr becomes $1235; busy is 1 for 4 cycles.
2. RAM dummy read: ctl=8'h60, ptr=$FFFF, ram_rdata=$5A -> first read returns the old latch (0); pointer wraps to $0000; second read returns $5A.
3. DOC write: ctl=8'h00, ptr_lo=$A0, write $01 -> exactly one doc_wr pulse with addr $A0 and data $01; ptr is unchanged.
4. DOC OIR read: ptr_lo=$E0, two reads -> doc_reg_addr=$E0 for exactly 1 cycle per read; the second read returns the captured doc_data_in; $E0 is never driven otherwise.
5. Busy and timeout: ram_ack held 0 -> data strobes during busy are ignored; after 15 cycles the block returns to IDLE with latch=$FF; a reset_n low pulse mid-access drops ram_req on the next edge.
6. Volume (GLU_VOLUME_EN defined): snd_in=16'h1000 with vol=8 -> 16'h0800; snd_in=16'h8000 with vol=15 -> 16'h8800. With the macro undefined -> snd_out=snd_in one cycle later.

Source files
------------

// File: rtl/sound_glu_pkg.sv
// Shared definitions for the Sound GLU host bridge: FSM states, host register
// indices, control-register bit positions and fixed DOC/RAM values.
package sound_glu_pkg;

  // Access sequencer states.
  typedef enum logic [2:0] {
    StIdle,
    StDocWr,
    StDocRd,
    StDocCap,
    StRamWr,
    StRamRd
  } glu_state_e;

  // Host register select ($C03C-$C03F).
  localparam logic [1:0] REG_CTL  = 2'd0;
  localparam logic [1:0] REG_DATA = 2'd1;
  localparam logic [1:0] REG_ALO  = 2'd2;
  localparam logic [1:0] REG_AHI  = 2'd3;

  // Control register bit positions; [3:0] is the master volume.
  localparam int unsigned CTL_AUTOINC = 5;
  localparam int unsigned CTL_RAM     = 6;
  localparam int unsigned CTL_BUSY    = 7;

  // Parking address for the DOC register bus; kept clear of the $E0-$E3
  // block so the OIR stack is never popped by accident.
  localparam logic [7:0] DOC_IDLE_ADDR = 8'h00;

  // Data latch value after an abandoned RAM read.
  localparam logic [7:0] TIMEOUT_DATA = 8'hFF;

endpackage

// File: rtl/sound_glu_volume.sv
// Master-volume stage for the DOC sound output.
// Optional feature macro: GLU_VOLUME_EN
//   defined   : snd_o = (signed snd_i * {1'b0, vol_i}) >>> 4, registered
//   undefined : snd_o = snd_i registered; vol_i has no effect
// Ports:
//   clk_i     system clock
//   reset_ni  synchronous active-low reset
//   vol_i     4-bit master volume (15 = 15/16 scale)
//   snd_i     signed 16-bit DOC sound sample
//   snd_o     scaled sample, one cycle latency
module sound_glu_volume (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic [3:0]  vol_i,
  input  logic [15:0] snd_i,
  output logic [15:0] snd_o
);

  logic [15:0] snd_d, snd_q;

`ifdef GLU_VOLUME_EN
  logic signed [20:0] snd_ext, vol_ext, prod;

  always_comb begin
    snd_ext = {{5{snd_i[15]}}, snd_i};
    vol_ext = {17'd0, vol_i};
    prod    = snd_ext * vol_ext;
    // Arithmetic shift by 4; |result| <= 32768 * 15/16 so 16 bits suffice.
    snd_d   = prod[19:4];
  end
`else
  logic unused_vol;
  assign unused_vol = ^vol_i;

  always_comb begin
    snd_d = snd_i;
  end
`endif

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      snd_q <= 16'h0000;
    end else begin
      snd_q <= snd_d;
    end
  end

  assign snd_o = snd_q;

endmodule

// File: rtl/sound_glu.sv
// IIgs Sound GLU: host bridge between the 65816 bus and the ES5503 DOC plus
// its sound RAM. Host registers: 0=control, 1=data, 2=addr_lo, 3=addr_hi.
// Data reads return the current latch and launch a fetch at the pointer
// (dummy-read semantics). RAM accesses use a req/ack arbiter port and are
// abandoned after RAM_TIMEOUT cycles without ack.
// Optional feature macro: GLU_VOLUME_EN (volume scaling, see sound_glu_volume).
// Ports:
//   clk_i, reset_ni            clock, synchronous active-low reset
//   cpu_addr_i/wr_i/rd_i/din_i host register select, strobes, write data
//   cpu_dout_o                 registered read data
//   doc_wr_o/reg_addr_o/reg_data_o, doc_data_in_i   DOC register interface
//   ram_req_o/we_o/addr_o/wdata_o, ram_rdata_i, ram_ack_i   sound RAM port
//   snd_in_i, snd_out_o        DOC sound in, volume-scaled sound out
module sound_glu
  import sound_glu_pkg::*;
#(
  parameter int unsigned RAM_AW      = 16,
  parameter int unsigned RAM_TIMEOUT = 15
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic [1:0]        cpu_addr_i,
  input  logic              cpu_wr_i,
  input  logic              cpu_rd_i,
  input  logic [7:0]        cpu_din_i,
  output logic [7:0]        cpu_dout_o,
  output logic              doc_wr_o,
  output logic [7:0]        doc_reg_addr_o,
  output logic [7:0]        doc_reg_data_o,
  input  logic [7:0]        doc_data_in_i,
  output logic              ram_req_o,
  output logic              ram_we_o,
  output logic [RAM_AW-1:0] ram_addr_o,
  output logic [7:0]        ram_wdata_o,
  input  logic [7:0]        ram_rdata_i,
  input  logic              ram_ack_i,
  input  logic [15:0]       snd_in_i,
  output logic [15:0]       snd_out_o
);

  localparam int unsigned TmoW = $clog2(RAM_TIMEOUT + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(RAM_TIMEOUT - 1);

  glu_state_e state_q, state_d;

  logic [6:0]      ctl_q, ctl_d;     // busy bit is derived, not stored
  logic [15:0]     ptr_q, ptr_d;
  logic [7:0]      latch_q, latch_d;
  logic [7:0]      wdata_q, wdata_d;
  logic [7:0]      dout_q, dout_d;
  logic [TmoW-1:0] tmo_q, tmo_d;

  logic busy, ram_state, tmo_expire, access_done;
  logic wr_en, rd_en, data_wr, data_rd;

  always_comb begin
    busy       = (state_q != StIdle);
    ram_state  = (state_q == StRamWr) || (state_q == StRamRd);
    tmo_expire = ram_state && !ram_ack_i && (tmo_q == TmoLast);
    // A write strobe suppresses a simultaneous read.
    wr_en      = cpu_wr_i;
    rd_en      = cpu_rd_i && !cpu_wr_i;
    data_wr    = wr_en && (cpu_addr_i == REG_DATA) && !busy;
    data_rd    = rd_en && (cpu_addr_i == REG_DATA) && !busy;
    access_done = (state_q == StDocWr) || (state_q == StDocCap) ||
                  (ram_state && (ram_ack_i || tmo_expire));
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (data_wr) begin
          state_d = ctl_q[CTL_RAM] ? StRamWr : StDocWr;
        end else if (data_rd) begin
          state_d = ctl_q[CTL_RAM] ? StRamRd : StDocRd;
        end
      end
      StDocWr:  state_d = StIdle;
      StDocRd:  state_d = StDocCap;
      StDocCap: state_d = StIdle;
      StRamWr, StRamRd: begin
        if (ram_ack_i || tmo_expire) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    doc_wr_o       = (state_q == StDocWr);
    // Only the access cycle carries the pointer; OIR pops need wr=0, so the
    // single DocRd cycle is the only read-side exposure of $E0-$E3.
    doc_reg_addr_o = ((state_q == StDocWr) || (state_q == StDocRd)) ? ptr_q[7:0]
                                                                    : DOC_IDLE_ADDR;
    doc_reg_data_o = wdata_q;
    ram_req_o      = ram_state;
    ram_we_o       = (state_q == StRamWr);
    ram_addr_o     = ptr_q[RAM_AW-1:0];
    ram_wdata_o    = wdata_q;
    cpu_dout_o     = dout_q;
  end

  // ----------------------------------------------------------- datapath
  always_comb begin
    ctl_d   = ctl_q;
    ptr_d   = ptr_q;
    latch_d = latch_q;
    wdata_d = wdata_q;
    dout_d  = dout_q;

    if (rd_en) begin
      unique case (cpu_addr_i)
        REG_CTL:  dout_d = {busy, ctl_q};
        REG_DATA: if (!busy) dout_d = latch_q;
        REG_ALO:  dout_d = ptr_q[7:0];
        REG_AHI:  dout_d = ptr_q[15:8];
        default:  dout_d = dout_q;
      endcase
    end

    if (wr_en) begin
      unique case (cpu_addr_i)
        REG_CTL: begin
          // Volume stays live during an access; mode bits are frozen.
          ctl_d[3:0] = cpu_din_i[3:0];
          if (!busy) ctl_d[6:4] = cpu_din_i[6:4];
        end
        REG_DATA: if (!busy) wdata_d = cpu_din_i;
        REG_ALO:  if (!busy) ptr_d[7:0] = cpu_din_i;
        REG_AHI:  if (!busy) ptr_d[15:8] = cpu_din_i;
        default:  ctl_d = ctl_q;
      endcase
    end

    if (state_q == StDocCap) begin
      latch_d = doc_data_in_i;
    end else if (state_q == StRamRd && ram_ack_i) begin
      latch_d = ram_rdata_i;
    end else if (state_q == StRamRd && tmo_expire) begin
      latch_d = TIMEOUT_DATA;
    end

    // Busy blocks pointer writes, so completion never collides with them.
    if (access_done && ctl_q[CTL_AUTOINC]) begin
      ptr_d = ptr_q + 16'd1;
    end

    tmo_d = (ram_state && !access_done) ? tmo_q + 1'b1 : '0;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      ctl_q   <= '0;
      ptr_q   <= '0;
      latch_q <= '0;
      wdata_q <= '0;
      dout_q  <= '0;
      tmo_q   <= '0;
    end else begin
      ctl_q   <= ctl_d;
      ptr_q   <= ptr_d;
      latch_q <= latch_d;
      wdata_q <= wdata_d;
      dout_q  <= dout_d;
      tmo_q   <= tmo_d;
    end
  end

  sound_glu_volume u_volume (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .vol_i    (ctl_q[3:0]),
    .snd_i    (snd_in_i),
    .snd_o    (snd_out_o)
  );

endmodule
